// File: rtl/z80_bus_resp.sv
// Z80 bus responder: turns CPU memory/I/O strobes into one back-end request per bus cycle
// and stretches the cycle with WAIT until mem_ack. Define Z80_BUS_TIMEOUT_EN for a wait timeout.
module z80_bus_resp #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cep,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        rfsh_n,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    output logic [7:0]  q,
    output logic        wait_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("z80_bus_resp: TIMEOUT must be in 1..255");
    end

    state_e      state_q, state_d;
    logic [7:0]  q_q, q_d;
    logic        wait_n_q, wait_n_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_io_q, mem_io_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        cycle_start;
    logic        bus_released;
`ifdef Z80_BUS_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    // Refresh cycles assert mreq_n with rfsh_n low and must never reach the back-end.
    assign cycle_start  = cep && ((!mreq_n && rfsh_n) || !iorq_n) && (!rd_n || !wr_n);
    assign bus_released = cep && ((mreq_n && iorq_n) || (rd_n && wr_n));

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        wait_n_d    = wait_n_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_io_d    = mem_io_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef Z80_BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (cycle_start) begin
                    mem_addr_d  = a;
                    mem_wdata_d = d;
                    mem_we_d    = !wr_n;
                    mem_io_d    = !iorq_n;
                    mem_req_d   = 1'b1;
                    wait_n_d    = 1'b0;
                    state_d     = StWait;
`ifdef Z80_BUS_TIMEOUT_EN
                    cnt_d       = 8'd0;
`endif
                end
            end
            StWait: begin
`ifdef Z80_BUS_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                // An ack coinciding with our own request pulse cannot belong to this cycle.
                if (mem_ack && !mem_req_q) begin
                    if (!mem_we_q) begin
                        q_d = mem_rdata;
                    end
                    wait_n_d = 1'b1;
                    state_d  = StHold;
                end
`ifdef Z80_BUS_TIMEOUT_EN
                else if (cnt_d == 8'(TIMEOUT)) begin
                    if (!mem_we_q) begin
                        q_d = 8'hFF;
                    end
                    wait_n_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = StHold;
                end
`endif
            end
            StHold: begin
                if (bus_released) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            q_q         <= 8'hFF;
            wait_n_q    <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_io_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
`ifdef Z80_BUS_TIMEOUT_EN
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            wait_n_q    <= wait_n_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_io_q    <= mem_io_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef Z80_BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign q         = q_q;
    assign wait_n    = wait_n_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_io    = mem_io_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
`ifdef Z80_BUS_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: doc/z80_bus_resp.md
Z80_BUS_RESP -- requirements
Module: z80_bus_resp

Interface
REQ-001 Parameter: TIMEOUT, default 255, wait-state limit in clock cycles (1..255), used only when Z80_BUS_TIMEOUT_EN is defined.
REQ-002 clock  input  1  system clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cep  input  1  CPU clock enable; strobes are sampled only on clocks where cep=1.
REQ-005 mreq_n, iorq_n, rd_n, wr_n, rfsh_n  input  1 each  active-low Z80 bus strobes from the CPU.
REQ-006 a  input  16  CPU address.
REQ-007 d  input  8  CPU write data.
REQ-008 q  output  8  read data to the CPU.
REQ-009 wait_n  output  1  active-low WAIT to the CPU.
REQ-010 mem_req  output  1  one-clock request pulse to the back-end.
REQ-011 mem_we, mem_io  output  1 each  write flag; I/O-space flag.
REQ-012 mem_addr  output  16  latched address.
REQ-013 mem_wdata  output  8  latched write data.
REQ-014 mem_rdata  input  8  back-end read data, valid with mem_ack.
REQ-015 mem_ack  input  1  one-clock back-end completion pulse.
REQ-016 err  output  1  one-clock timeout pulse.

Function
REQ-017 FSM states: IDLE, WAIT, HOLD.
REQ-018 IDLE: cycle start on cep=1 with (mreq_n=0, rfsh_n=1) or iorq_n=0, and rd_n=0 or wr_n=0.
REQ-019 Refresh cycles (mreq_n=0, rfsh_n=0) never start a cycle.
REQ-020 On cycle start, in the same edge: latch a->mem_addr, d->mem_wdata, (wr_n==0)->mem_we, (iorq_n==0)->mem_io; set mem_req=1 and wait_n=0; enter WAIT.
REQ-021 mem_req is high for exactly one clock per cycle.
REQ-022 wait_n stays 0 throughout WAIT.
REQ-023 WAIT: on mem_ack=1, if read then q<=mem_rdata, else q unchanged; wait_n<=1; enter HOLD.
REQ-024 mem_ack is ignored in IDLE and HOLD, and on the clock mem_req is asserted.
REQ-025 HOLD: remain until (mreq_n=1 and iorq_n=1) or (rd_n=1 and wr_n=1), sampled with cep=1; then enter IDLE.
REQ-026 Minimum cycle latency: request to wait_n release is 2 clocks (req, then ack the following clock).
REQ-027 Strobe release during WAIT does not abort the cycle; on ack, HOLD exits on the next cep.
REQ-028 One back-end request per bus cycle; a held strobe never re-triggers.

Reset
REQ-029 Reset forces IDLE immediately, regardless of clock.
REQ-030 Reset values: wait_n=1, mem_req=0, mem_we=0, mem_io=0, mem_addr=0, mem_wdata=0, q=8'hFF, err=0, timeout counter=0.
REQ-031 Reset mid-cycle releases wait_n at once.
REQ-032 A late mem_ack after reset is ignored.

Configuration
REQ-033 Macro Z80_BUS_TIMEOUT_EN, defined: an 8-bit counter clears on WAIT entry and increments each clock in WAIT.
REQ-034 With the macro, when the count reaches TIMEOUT without ack: q<=8'hFF if read, wait_n<=1, err=1 for one clock, enter HOLD.
REQ-035 Macro undefined: no counter, err tied 0, WAIT holds indefinitely until mem_ack.

Verification
REQ-036 Memory read: mreq_n=0, rd_n=0, a=16'h4000, ack after 3 clocks with mem_rdata=8'h5A -> mem_req one clock, mem_we=0, mem_io=0, wait_n low 4 clocks, q=8'h5A.
REQ-037 I/O write: iorq_n=0, wr_n=0, a=16'h00FF, d=8'hC3, immediate ack -> mem_io=1, mem_we=1, mem_addr=16'h00FF, mem_wdata=8'hC3, q stays 8'hFF.
REQ-038 Refresh: mreq_n=0, rfsh_n=0, rd_n=1 for 10 clocks -> no mem_req, wait_n=1.
REQ-039 Reset asserted in WAIT, then mem_ack pulsed -> wait_n=1 immediately, state IDLE, q unchanged at 8'hFF.
REQ-040 Timeout with macro defined, TIMEOUT=16, read, no ack -> err pulse on count 16, q=8'hFF, wait_n=1.
REQ-041 Timeout, macro undefined -> wait_n stays 0 for 300 clocks.
REQ-042 Held strobe: rd_n=0 kept for 20 clocks after ack -> exactly one mem_req.
